// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data-memory responder: FSM states,
// illegal-request causes and the request legality check.
package data_mem_pkg;

  localparam int unsigned DEF_LATENCY     = 4;
  localparam int unsigned DEF_DEPTH_WORDS = 256;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_BOTH,
    CAUSE_MISALIGN,
    CAUSE_RANGE
  } err_cause_e;

  // First matching cause wins; the order is part of the contract.
  function automatic err_cause_e classify(input logic        rd,
                                          input logic        wr,
                                          input logic [31:0] addr,
                                          input int unsigned depth);
    if (rd && wr)                     return CAUSE_BOTH;
    if (addr[1:0] != 2'b00)           return CAUSE_MISALIGN;
    if (32'(addr[31:2]) >= depth)     return CAUSE_RANGE;
    return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// MEM-stage data-memory port: request from the pipeline, response and
// stall from the responder.
interface data_mem_resp_if;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        ack_o;
  logic        err_o;

  modport master (
    output addr_i, data_i, MemRead_i, MemWrite_i,
    input  data_o, stall_o, ack_o, err_o
  );

  modport slave (
    input  addr_i, data_i, MemRead_i, MemWrite_i,
    output data_o, stall_o, ack_o, err_o
  );
endinterface

// File: rtl/data_mem_resp_mem_array.sv
// Single-port synchronous word array with a one-cycle registered read.
module mem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: the storage array has no reset; resetting it would turn a RAM
  // macro into a flop array and its contents are not architecturally defined.
  always_ff @(posedge clk_i) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_resp.sv
// Multi-cycle data-memory responder: holds the pipeline while a fixed-latency
// word array is accessed, then pulses ack (and err for illegal requests).
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned LATENCY     = DEF_LATENCY
) (
  input logic             clk_i,
  input logic             rst_n_i,
  data_mem_resp_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(LATENCY) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               is_store_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic [31:0]        data_q;

  logic               req;
  err_cause_e         cause;
  logic               latch, capture, we, stall, ack, err_out;
  logic [IDX_W-1:0]   mem_idx;
  logic [31:0]        rdata;

  assign req   = bus.MemRead_i | bus.MemWrite_i;
  assign cause = classify(bus.MemRead_i, bus.MemWrite_i, bus.addr_i, DEPTH_WORDS);

  // NOTE: every output of this block is assigned a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    latch   = 1'b0;
    capture = 1'b0;
    we      = 1'b0;
    stall   = 1'b0;
    ack     = 1'b0;
    err_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          stall = 1'b1;
          if (cause == CAUSE_NONE) begin
            latch   = 1'b1;
            cnt_d   = CNT_W'(LATENCY - 1);
            err_d   = 1'b0;
            state_d = BUSY;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          we      = is_store_q;
          capture = ~is_store_q;
          state_d = DONE;
        end
      end
      DONE: begin
        ack     = 1'b1;
        err_out = err_q;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      is_store_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (latch) begin
        is_store_q <= bus.MemWrite_i;
        idx_q      <= bus.addr_i[2 +: IDX_W];
        wdata_q    <= bus.data_i;
      end
      if (capture) data_q <= rdata;
    end
  end

  // In IDLE the array is addressed straight from the request so that a
  // single-cycle latency still has its read data by the commit edge.
  assign mem_idx = (state_q == IDLE) ? bus.addr_i[2 +: IDX_W] : idx_q;

  mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clk_i (clk_i),
    .we    (we),
    .idx   (mem_idx),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  assign bus.data_o  = data_q;
  assign bus.stall_o = stall & rst_n_i;
  assign bus.ack_o   = ack;
  assign bus.err_o   = err_out;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: two instances (LATENCY 4 and 1) checked every
// cycle against a timing/memory model, plus literal spot checks.
module tb_data_mem_resp;

  logic clk_i = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk_i = ~clk_i;

  data_mem_resp_if bus_a ();
  data_mem_resp_if bus_b ();

  data_mem_resp #(.DEPTH_WORDS(256), .LATENCY(4)) u_a (
    .clk_i (clk_i), .rst_n_i (rst_a), .bus (bus_a)
  );
  data_mem_resp #(.DEPTH_WORDS(256), .LATENCY(1)) u_b (
    .clk_i (clk_i), .rst_n_i (rst_b), .bus (bus_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  logic        exp_stall [2];
  logic        exp_ack   [2];
  logic        exp_err   [2];
  logic [31:0] exp_data  [2];
  logic [31:0] mem_m     [2][256];

  int stall_cnt [2];
  int stall_lo  [2];
  int ack_cyc   [2];
  bit err_seen  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_i) cyc = cyc + 1;

  // Single compare process: every cycle, both instances against the model.
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("a_stall", 32'(bus_a.stall_o), 32'(exp_stall[0]));
      check("a_ack",   32'(bus_a.ack_o),   32'(exp_ack[0]));
      check("a_err",   32'(bus_a.err_o),   32'(exp_err[0]));
      check("a_data",  bus_a.data_o,       exp_data[0]);
      check("b_stall", 32'(bus_b.stall_o), 32'(exp_stall[1]));
      check("b_ack",   32'(bus_b.ack_o),   32'(exp_ack[1]));
      check("b_err",   32'(bus_b.err_o),   32'(exp_err[1]));
      check("b_data",  bus_b.data_o,       exp_data[1]);
      if (bus_a.stall_o) stall_cnt[0]++;
      if (bus_b.stall_o) stall_cnt[1]++; else stall_lo[1]++;
      if (bus_a.ack_o) ack_cyc[0] = cyc;
      if (bus_b.ack_o) ack_cyc[1] = cyc;
      if (bus_a.err_o) err_seen[0] = 1'b1;
      if (bus_b.err_o) err_seen[1] = 1'b1;
    end
  end

  task automatic drive(input int d, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (d == 0) begin
      bus_a.MemRead_i = rd; bus_a.MemWrite_i = wr; bus_a.addr_i = addr; bus_a.data_i = wd;
    end else begin
      bus_b.MemRead_i = rd; bus_b.MemWrite_i = wr; bus_b.addr_i = addr; bus_b.data_i = wd;
    end
  endtask

  task automatic set_idle(input int d);
    exp_stall[d] = 1'b0;
    exp_ack[d]   = 1'b0;
    exp_err[d]   = 1'b0;
  endtask

  // One request from its first cycle through the ack cycle. Legal requests
  // stall for LATENCY+1 cycles and ack in cycle LATENCY+1; illegal ones stall
  // one cycle and ack/err in cycle 1. Entered and left at posedge+1.
  task automatic run_req(input int d, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wd);
    int lat    = (d == 0) ? 4 : 1;
    bit legal  = !(rd && wr) && (addr[1:0] == 2'b00) && (addr[31:2] < 30'd256);
    int n      = legal ? lat + 2 : 2;
    drive(d, rd, wr, addr, wd);
    for (int k = 0; k < n; k++) begin
      exp_stall[d] = (k < n - 1);
      exp_ack[d]   = (k == n - 1);
      exp_err[d]   = (k == n - 1) && !legal;
      if (k == n - 1 && legal && rd) exp_data[d] = mem_m[d][addr[9:2]];
      @(posedge clk_i); #1;
    end
    if (legal && wr) mem_m[d][addr[9:2]] = wd;
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
    set_idle(d);
  endtask

  task automatic clear_obs(input int d);
    stall_cnt[d] = 0;
    stall_lo[d]  = 0;
    err_seen[d]  = 1'b0;
    ack_cyc[d]   = -1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  initial begin
    int t0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int d = 0; d < 2; d++) begin
      set_idle(d);
      exp_data[d] = 32'h0;
      clear_obs(d);
    end
    #2 rst_a = 1'b0; rst_b = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_a = 1'b1; rst_b = 1'b1;

    check("rst_stall", 32'(bus_a.stall_o), 32'h0);
    check("rst_ack",   32'(bus_a.ack_o),   32'h0);
    check("rst_data",  bus_a.data_o,       32'h0);

    // Seed known words on instance A, including the last legal word.
    run_req(0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0C0D);
    run_req(0, 1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_0020);
    run_req(0, 1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D);

    // Store then load 0x10.
    clear_obs(0); t0 = cyc;
    run_req(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    check("st_stalls",  32'(stall_cnt[0]),   32'd5);
    check("st_ack_cyc", 32'(ack_cyc[0] - t0), 32'd5);
    check("st_err",     32'(err_seen[0]),    32'd0);
    clear_obs(0); t0 = cyc;
    run_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    check("ld_stalls",  32'(stall_cnt[0]),   32'd5);
    check("ld_ack_cyc", 32'(ack_cyc[0] - t0), 32'd5);
    check("ld_data",    bus_a.data_o,        32'hDEAD_BEEF);
    check("ld_err",     32'(err_seen[0]),    32'd0);

    // Misaligned load.
    clear_obs(0); t0 = cyc;
    run_req(0, 1'b1, 1'b0, 32'h0000_0012, 32'h0);
    check("mis_stalls",  32'(stall_cnt[0]),   32'd1);
    check("mis_ack_cyc", 32'(ack_cyc[0] - t0), 32'd1);
    check("mis_err",     32'(err_seen[0]),    32'd1);
    check("mis_data",    bus_a.data_o,        32'hDEAD_BEEF);

    // Out-of-range store, then load of word 0.
    clear_obs(0);
    run_req(0, 1'b0, 1'b1, 32'h0000_0400, 32'h5555_5555);
    check("rng_err", 32'(err_seen[0]), 32'd1);
    run_req(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
    check("rng_w0", bus_a.data_o, 32'h0000_0C0D);

    // Read and write together: error, no write.
    clear_obs(0);
    run_req(0, 1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
    check("both_err", 32'(err_seen[0]), 32'd1);
    run_req(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
    check("both_w0", bus_a.data_o, 32'h0000_0C0D);

    // Highest legal word.
    run_req(0, 1'b1, 1'b0, 32'h0000_03FC, 32'h0);
    check("top_word", bus_a.data_o, 32'hCAFE_F00D);

    // Store to 0x20 abandoned by a reset pulse in cycle 2.
    drive(0, 1'b0, 1'b1, 32'h0000_0020, 32'h0000_1234);
    exp_stall[0] = 1'b1;
    idle_cycles(2);
    rst_a = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_idle(0);
    exp_data[0] = 32'h0;
    @(posedge clk_i); #1;
    rst_a = 1'b1;
    idle_cycles(1);
    run_req(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    check("rst_keep", bus_a.data_o, 32'hA5A5_0020);

    // Instance B (LATENCY 1): seed, then back-to-back loads of 0x0 and 0x4.
    run_req(1, 1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111);
    run_req(1, 1'b0, 1'b1, 32'h0000_0004, 32'h2222_2222);
    idle_cycles(1);
    clear_obs(1); t0 = cyc;
    run_req(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
    check("b2b_ack1", 32'(ack_cyc[1] - t0), 32'd2);
    check("b2b_d1",   bus_b.data_o,         32'h1111_1111);
    run_req(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
    check("b2b_ack2", 32'(ack_cyc[1] - t0), 32'd5);
    check("b2b_lo",   32'(stall_lo[1]),     32'd2);
    check("b2b_d2",   bus_b.data_o,         32'h2222_2222);

    // Store immediately followed by a load of the same word.
    run_req(1, 1'b0, 1'b1, 32'h0000_0008, 32'h3333_3333);
    run_req(1, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
    check("st_ld_fwd", bus_b.data_o, 32'h3333_3333);

    idle_cycles(2);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Multi-cycle responder for the pipeline's data-memory port. The block sits behind the EX/MEM register and accepts one load or store at a time, using the `MemRead_i`/`MemWrite_i`, address and store-data signals that the MEM stage drives today. It holds the pipeline with `stall_o` while a fixed-latency word array is accessed. It reports completion with a one-cycle `ack_o`, and reports illegal requests with `err_o`.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of 32-bit words in the backing array; must be a power of two, ≥ 2.
- `LATENCY`, default 4: number of array-access cycles per legal request; must be ≥ 1.

Ports (clock is `clk_i`; reset is asynchronous, active-low, `rst_n_i`):
- `clk_i` in 1: the single clock.
- `rst_n_i` in 1: asynchronous active-low reset.
- `addr_i` in 32: byte address (ALU result).
- `data_i` in 32: store data.
- `MemRead_i` in 1: load request.
- `MemWrite_i` in 1: store request.
- `data_o` out 32: load data; valid in the `ack_o` cycle and held until the next successful load.
- `stall_o` out 1: pipeline hold; PC, IF/ID, ID/EX, EX/MEM and MEM/WB must not update while it is high.
- `ack_o` out 1: one-cycle completion pulse.
- `err_o` out 1: one-cycle error pulse, coincident with `ack_o`.

## Operation
- A request is present when `MemRead_i | MemWrite_i`.
- The requester holds `addr_i`, `data_i`, `MemRead_i` and `MemWrite_i` stable while `stall_o` = 1 and through the `ack_o` cycle.
- State machine with three states: IDLE, BUSY, DONE.
  - IDLE, no request: `stall_o` = 0; stay in IDLE.
  - IDLE, legal request: `stall_o` = 1 (combinational); latch op, word index and data; load counter with `LATENCY-1`; go to BUSY.
  - IDLE, illegal request: `stall_o` = 1; set the error flag; go directly to DONE with no array access.
  - BUSY: `stall_o` = 1.
    - Counter ≠ 0: decrement.
    - Counter = 0: perform the access (store: write the word; load: capture the word into `data_o`); go to DONE.
  - DONE: `ack_o` = 1, `err_o` = error flag, `stall_o` = 0. The pipeline advances on this edge. Any request visible in DONE is the old, completed one and is ignored. Go to IDLE.
- Illegal requests, checked in priority order:
  - `MemRead_i` & `MemWrite_i` both high.
  - `addr_i[1:0]` ≠ 0 (misaligned).
  - `addr_i[31:2]` ≥ `DEPTH_WORDS` (out of range).
- On an error: `data_o` is unchanged and the array is unchanged.
- Word index is `addr_i[2 +: $clog2(DEPTH_WORDS)]`, taken only after the range check passes. Addresses never wrap.
- Stores write the full 32 bits. There are no byte enables.
- Reset:
  - Reset values: state = IDLE, counter = 0, error flag = 0, `data_o` = 0, `ack_o` = 0, `err_o` = 0.
  - `stall_o` is forced to 0 while `rst_n_i` = 0.
  - Array contents are not reset.
  - Reset mid-BUSY abandons the request. A store whose commit edge has not occurred does not write.

## Timing
- Legal request first seen in cycle 0:
  - `stall_o` is high in cycles 0 … `LATENCY`.
  - `ack_o` is high in cycle `LATENCY+1`.
  - Load data appears on `data_o` in cycle `LATENCY+1`.
- Illegal request: `stall_o` is high in cycle 0 only; `ack_o` and `err_o` are high in cycle 1.
- The earliest next acceptance is the cycle after DONE. Minimum request spacing is `LATENCY+2` cycles.
- A store followed immediately by a load to the same word returns the new data.
- Counter width is `$clog2(LATENCY)+1`; it never underflows.

## Structure
- Package `data_mem_pkg`:
  - state enum (IDLE, BUSY, DONE)
  - default `LATENCY` and default `DEPTH_WORDS` constants
  - illegal-cause encoding (BOTH, MISALIGN, RANGE) for debug visibility
- Sub-module `mem_array`: single-port synchronous word array with inputs `we`, `idx`, `wdata` and output `rdata`, one-cycle read. The FSM issues the read on the counter = 1 edge so that the capture aligns with counter = 0. For `LATENCY` = 1, the read is issued on the IDLE→BUSY edge.
- The FSM, the counter and the legality check live in `data_mem_resp`.

## Test plan
- Store `0xDEADBEEF` to `0x10` (`LATENCY` = 4), then load `0x10`:
  - each access has 5 stall cycles and `ack_o` in cycle 5;
  - the load returns `data_o` = `0xDEADBEEF`;
  - `err_o` stays 0.
- Load from `0x12`: 1 stall cycle, `ack_o` = `err_o` = 1 in cycle 1, `data_o` unchanged.
- Store to `0x400` with `DEPTH_WORDS` = 256: `err_o` pulses; a subsequent load of `0x0` still returns its prior value.
- `MemRead_i` = `MemWrite_i` = 1: `err_o` pulses; no array write occurs.
- Store `0x1234` to `0x20` with `rst_n_i` pulsed low in cycle 2: all outputs go to 0 immediately; after release, a load of `0x20` returns the old contents.
- Back-to-back loads of `0x0` and `0x4` with `LATENCY` = 1:
  - `ack_o` in cycles 2 and 5;
  - `stall_o` is low in exactly one cycle (the DONE cycle) between the two accesses.
